// File: rtl/reg_port_sequencer.sv
// reg_port_sequencer
// Turns read / write / dump commands into timed register-file port activity
// and returns one response per register touched.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   req_*               command channel (valid/ready); op 00 rd, 01 wr, 10 dump, 11 reserved
//   rsp_*               response channel (valid/ready); payload frozen until rsp_ready
//   rf_write_*          register-file write port (enable is a single-cycle pulse)
//   rf_read_addr/data   register-file read port 1 (data expected within one cycle)
//   busy                high whenever a command is in flight
//
// Every output is a flop loaded from the value it must have in the next
// state, so outputs change only on clk edges.
module reg_port_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_CAP, RESP} state_t;

  localparam logic [1:0]        OP_RD    = 2'b00;
  localparam logic [1:0]        OP_WR    = 2'b01;
  localparam logic [1:0]        OP_DUMP  = 2'b10;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, ptr_q, ptr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
  logic                rsp_err_q, rsp_err_d, rsp_last_q, rsp_last_d;
  logic                rf_write_en_q, rf_write_en_d;
  logic [ADDR_W-1:0]   rf_write_addr_q, rf_write_addr_d, rf_read_addr_q, rf_read_addr_d;
  logic [DATA_W-1:0]   rf_write_data_q, rf_write_data_d;
  logic                busy_q, busy_d;
  logic                accept;

  assign accept = req_valid & req_ready_q;

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    ptr_d           = ptr_q;
    rsp_data_d      = rsp_data_q;
    rsp_addr_d      = rsp_addr_q;
    rsp_err_d       = rsp_err_q;
    rsp_last_d      = rsp_last_q;
    rf_write_addr_d = rf_write_addr_q;
    rf_write_data_d = rf_write_data_q;
    rf_read_addr_d  = rf_read_addr_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          ptr_d   = '0;
          if (req_op == OP_WR && req_addr != '0) begin
            state_d         = WRITE;
            rf_write_addr_d = req_addr;
            rf_write_data_d = req_wdata;
          end else if (req_op == OP_RD) begin
            state_d        = RD_ADDR;
            rf_read_addr_d = req_addr;
          end else if (req_op == OP_DUMP) begin
            state_d        = RD_ADDR;
            rf_read_addr_d = '0;
          end else begin
            // R0 is hardwired zero, so a write to it is refused like a
            // reserved op: straight to an error response, no port activity.
            state_d    = RESP;
            rsp_data_d = '0;
            rsp_addr_d = req_addr;
            rsp_err_d  = 1'b1;
            rsp_last_d = 1'b1;
          end
        end
      end
      WRITE: begin
        state_d    = RESP;
        rsp_data_d = wdata_q;
        rsp_addr_d = addr_q;
        rsp_err_d  = 1'b0;
        rsp_last_d = 1'b1;
      end
      RD_ADDR: state_d = RD_CAP;
      RD_CAP: begin
        // Address has been stable for two cycles by this edge.
        state_d    = RESP;
        rsp_data_d = rf_read_data;
        rsp_err_d  = 1'b0;
        if (op_q == OP_DUMP) begin
          rsp_addr_d = ptr_q;
          rsp_last_d = (ptr_q == PTR_LAST);
        end else begin
          rsp_addr_d = addr_q;
          rsp_last_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          // Dump stops at the last register before incrementing, so the
          // pointer never wraps.
          if (op_q == OP_DUMP && ptr_q != PTR_LAST) begin
            state_d        = RD_ADDR;
            ptr_d          = ptr_q + ADDR_W'(1);
            rf_read_addr_d = ptr_q + ADDR_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rf_write_en_d = (state_d == WRITE);
    rsp_valid_d   = (state_d == RESP);
    req_ready_d   = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      op_q            <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      ptr_q           <= '0;
      req_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_addr_q      <= '0;
      rsp_err_q       <= 1'b0;
      rsp_last_q      <= 1'b0;
      rf_write_en_q   <= 1'b0;
      rf_write_addr_q <= '0;
      rf_write_data_q <= '0;
      rf_read_addr_q  <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      ptr_q           <= ptr_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_addr_q      <= rsp_addr_d;
      rsp_err_q       <= rsp_err_d;
      rsp_last_q      <= rsp_last_d;
      rf_write_en_q   <= rf_write_en_d;
      rf_write_addr_q <= rf_write_addr_d;
      rf_write_data_q <= rf_write_data_d;
      rf_read_addr_q  <= rf_read_addr_d;
      busy_q          <= busy_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_addr      = rsp_addr_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_last      = rsp_last_q;
  assign rf_write_en   = rf_write_en_q;
  assign rf_write_addr = rf_write_addr_q;
  assign rf_write_data = rf_write_data_q;
  assign rf_read_addr  = rf_read_addr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_reg_port_sequencer.sv
// Bench for reg_port_sequencer: an 8x8 register-file model on the ports,
// a reference model that predicts responses from the command rules, and
// one task per scenario.
module tb_reg_port_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0] req_op;
  logic [2:0] req_addr, rsp_addr, rf_write_addr, rf_read_addr;
  logic [7:0] req_wdata, rsp_data, rf_write_data, rf_read_data;
  logic       rsp_err, rsp_last, rf_write_en, busy;

  always #5 clk = ~clk;

  reg_port_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .rsp_last(rsp_last),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data), .busy(busy)
  );

  // Register file: R0 reads zero, asynchronous read, write on the edge.
  logic [7:0] rf_mem [8] = '{default: 8'h00};
  assign rf_read_data = rf_mem[rf_read_addr];

  int         wr_cnt = 0;
  logic [2:0] last_wa;
  logic [7:0] last_wd;
  always @(posedge clk) begin
    if (rf_write_en === 1'b1) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= rf_write_addr;
      last_wd <= rf_write_data;
      if (rf_write_addr != 3'd0) rf_mem[rf_write_addr] <= rf_write_data;
    end
  end

  int n_chk = 0, n_pass = 0;

  // Response packed as {last, err, addr[2:0], data[7:0]}.
  typedef logic [12:0] rsp_t;
  rsp_t got_q[$], exp_q[$];
  logic [7:0] exp_regs [8] = '{default: 8'h00};
  int   first_lat, last_hs, stall_bad, rdy_bad, wr_before, exp_wr;
  bit   tmo, ready_after;

  // Reference model: what the command should return, from the op rules.
  task automatic model(input logic [1:0] op, input logic [2:0] a, input logic [7:0] d);
    exp_q.delete();
    exp_wr = 0;
    case (op)
      2'b00: exp_q.push_back({1'b1, 1'b0, a, exp_regs[a]});
      2'b01: if (a == 3'd0) exp_q.push_back({1'b1, 1'b1, 3'd0, 8'h00});
             else begin exp_q.push_back({1'b1, 1'b0, a, d}); exp_regs[a] = d; exp_wr = 1; end
      2'b10: for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 1'b0, 3'(i), exp_regs[i]});
      default: exp_q.push_back({1'b1, 1'b1, a, 8'h00});
    endcase
  endtask

  // Driver/collector. mode: 0 ready high, 1 ready toggling, 2 ready random.
  task automatic do_cmd(input logic [1:0] op, input logic [2:0] a, input logic [7:0] d, input int mode);
    int n, cyc;
    bit done, stalled, rdy;
    rsp_t cur, prev;
    got_q.delete();
    first_lat = 0; last_hs = 0; stall_bad = 0; rdy_bad = 0; tmo = 0; ready_after = 0;
    wr_before = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin tmo = 1; req_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'($urandom); req_addr = 3'($urandom); req_wdata = 8'($urandom);
    cyc = 1; done = 0; stalled = 0; prev = '0;
    while (!done && cyc < 300) begin
      if (req_ready) rdy_bad++;
      if (rsp_valid) begin
        cur = {rsp_last, rsp_err, rsp_addr, rsp_data};
        if (first_lat == 0) first_lat = cyc;
        if (stalled && cur !== prev) stall_bad++;
        rdy = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
        rsp_ready = rdy;
        if (rdy) begin
          got_q.push_back(cur); last_hs = cyc; stalled = 0;
          if (rsp_last) done = 1;
        end else begin
          stalled = 1; prev = cur;
        end
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
        stalled = 0;
      end
      @(negedge clk);
      cyc++;
    end
    rsp_ready = 1'b0;
    ready_after = req_ready;
    if (!done) tmo = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom); req_op = 2'($urandom); req_addr = 3'($urandom);
      req_wdata = 8'($urandom); rsp_ready = 1'($urandom);
      #1;
      n_chk++;
      if ({req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, rsp_last, rf_write_en,
           rf_write_addr, rf_write_data, rf_read_addr, busy} !== 37'd0)
        $display("FAIL reset_outputs cycle %0d: outputs not all zero (req_ready=%b rsp_valid=%b busy=%b)",
                 i, req_ready, rsp_valid, busy);
      else n_pass++;
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 1'b0) $display("FAIL ready_before_edge got=%b exp=0", req_ready); else n_pass++;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL ready_after_release got ready=%b busy=%b exp ready=1 busy=0", req_ready, busy);
    else n_pass++;
    // Reset must not disturb the counter baseline used by later tests.
    n_chk++;
    if (wr_cnt != 0) $display("FAIL reset_no_write got=%0d exp=0", wr_cnt); else n_pass++;
  endtask

  task automatic test_write_read();
    model(2'b01, 3'd3, 8'hA5);
    do_cmd(2'b01, 3'd3, 8'hA5, 0);
    n_chk++;
    if (got_q.size() != exp_q.size()) $display("FAIL wr3 rsp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) $display("FAIL wr3 rsp[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_chk++;
    if (wr_cnt - wr_before != 1 || last_wa !== 3'd3 || last_wd !== 8'hA5)
      $display("FAIL wr3_pulse got cycles=%0d addr=%0d data=%h exp cycles=1 addr=3 data=a5", wr_cnt - wr_before, last_wa, last_wd);
    else n_pass++;
    n_chk++;
    if (first_lat != 2) $display("FAIL wr3_latency got=%0d exp=2", first_lat); else n_pass++;

    model(2'b00, 3'd3, 8'h00);
    do_cmd(2'b00, 3'd3, 8'h00, 0);
    n_chk++;
    if (got_q.size() != exp_q.size()) $display("FAIL rd3 rsp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) $display("FAIL rd3 rsp[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_chk++;
    if (first_lat != 3) $display("FAIL rd3_latency got=%0d exp=3", first_lat); else n_pass++;
    n_chk++;
    if (ready_after !== 1'b1) $display("FAIL rd3_ready_return got=%b exp=1", ready_after); else n_pass++;
  endtask

  task automatic test_write_r0();
    model(2'b01, 3'd0, 8'hFF);
    do_cmd(2'b01, 3'd0, 8'hFF, 0);
    n_chk++;
    if (got_q.size() != exp_q.size()) $display("FAIL wr0 rsp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) $display("FAIL wr0 rsp[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_chk++;
    if (wr_cnt != wr_before) $display("FAIL wr0_no_pulse got=%0d exp=0", wr_cnt - wr_before); else n_pass++;
    model(2'b00, 3'd0, 8'h00);
    do_cmd(2'b00, 3'd0, 8'h00, 2);
    n_chk++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0])
      $display("FAIL rd0 got=%h exp=%h count=%0d", (got_q.size() > 0) ? got_q[0] : 13'h0, exp_q[0], got_q.size());
    else n_pass++;
  endtask

  task automatic test_dump();
    for (int r = 1; r < 8; r++) begin
      model(2'b01, 3'(r), 8'(r * 17));
      do_cmd(2'b01, 3'(r), 8'(r * 17), 0);
    end
    model(2'b10, 3'($urandom), 8'h00);
    do_cmd(2'b10, 3'($urandom), 8'($urandom), 1);
    n_chk++;
    if (got_q.size() != exp_q.size()) $display("FAIL dump rsp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) $display("FAIL dump rsp[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_chk++;
    if (stall_bad != 0 || rdy_bad != 0) $display("FAIL dump_stall got stall_changes=%0d ready_while_busy=%0d exp 0/0", stall_bad, rdy_bad); else n_pass++;
    n_chk++;
    if (wr_cnt != wr_before) $display("FAIL dump_no_write got=%0d exp=0", wr_cnt - wr_before); else n_pass++;
    // Full-rate dump: eight handshakes, the last 24 cycles after accept.
    model(2'b10, 3'd0, 8'h00);
    do_cmd(2'b10, 3'd0, 8'h00, 0);
    n_chk++;
    if (got_q.size() != 8 || last_hs != 24) $display("FAIL dump_rate got count=%0d last_hs=%0d exp 8/24", got_q.size(), last_hs); else n_pass++;
  endtask

  task automatic test_reserved();
    logic [2:0] ra;
    logic [2:0] a;
    ra = rf_read_addr;
    a  = 3'($urandom);
    model(2'b11, a, 8'h5C);
    do_cmd(2'b11, a, 8'h5C, 2);
    n_chk++;
    if (got_q.size() != 1) $display("FAIL rsv rsp_count got=%0d exp=1", got_q.size()); else n_pass++;
    n_chk++;
    if (got_q.size() > 0 && (got_q[0] & 13'h18FF) !== (exp_q[0] & 13'h18FF))
      $display("FAIL rsv rsp got=%h exp(last,err,data)=%h", got_q[0], exp_q[0] & 13'h18FF);
    else n_pass++;
    n_chk++;
    if (wr_cnt != wr_before || rf_read_addr !== ra)
      $display("FAIL rsv_no_rf got writes=%0d read_addr=%0d exp 0/%0d", wr_cnt - wr_before, rf_read_addr, ra);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int wb;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_addr = 3'd0; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wb = wr_cnt;
    repeat (7) @(negedge clk);
    // Now in the capture cycle of the third dump entry.
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0 || rf_write_en !== 1'b0)
      $display("FAIL mid_reset got rsp_valid=%b busy=%b req_ready=%b wen=%b exp all 0", rsp_valid, busy, req_ready, rf_write_en);
    else n_pass++;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (wr_cnt != wb || rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL mid_reset_after got writes=%0d rsp_valid=%b ready=%b exp 0/0/1", wr_cnt - wb, rsp_valid, req_ready);
    else n_pass++;
    model(2'b00, 3'd5, 8'h00);
    do_cmd(2'b00, 3'd5, 8'h00, 0);
    n_chk++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0] || first_lat != 3)
      $display("FAIL mid_reset_read got=%h lat=%0d count=%0d exp=%h lat=3", (got_q.size() > 0) ? got_q[0] : 13'h0, first_lat, got_q.size(), exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [2:0] a;
    logic [7:0] d;
    logic [12:0] m;
    int tot_bad;
    tot_bad = 0;
    for (int k = 0; k < 30; k++) begin
      op = 2'($urandom); a = 3'($urandom); d = 8'($urandom);
      m  = (op == 2'b11) ? 13'h18FF : 13'h1FFF;
      model(op, a, d);
      do_cmd(op, a, d, 2);
      n_chk++;
      if (got_q.size() != exp_q.size()) $display("FAIL rand%0d rsp_count op=%0d got=%0d exp=%0d", k, op, got_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_chk++;
        if ((got_q[i] & m) !== (exp_q[i] & m)) $display("FAIL rand%0d rsp[%0d] op=%0d got=%h exp=%h", k, i, op, got_q[i], exp_q[i]); else n_pass++;
      end
      n_chk++;
      if (wr_cnt - wr_before != exp_wr) $display("FAIL rand%0d writes op=%0d got=%0d exp=%0d", k, op, wr_cnt - wr_before, exp_wr); else n_pass++;
      tot_bad += stall_bad + rdy_bad + (ready_after ? 0 : 1) + (tmo ? 1 : 0);
    end
    n_chk++;
    if (tot_bad != 0) $display("FAIL rand_protocol got violations=%0d exp=0", tot_bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_r0();
    test_dump();
    test_reserved();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
